// File: rtl/spi_slave_rx.sv
// spi_slave_rx: SPI mode-0 (CPOL=0, CPHA=0) slave deserialiser.
// sclk, cs_n and mosi are oversampled in the clk domain. MSB-first words are
// assembled onto dout with a one-cycle done strobe. tx_data is shifted back
// on miso, one response word per received word.
// Interface timing: done and frame_err are single-cycle strobes with no
// back-pressure. A consumer must take dout in the cycle done is high, or
// before the next done. dout holds its value between strobes.
module spi_slave_rx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] dout,
    output logic              done,
    output logic              frame_err,
    output logic              busy,
    output logic [1:0]        state_dbg   // 0 = WAIT_CS, 1 = IDLE, 2 = SHIFT
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam int FL_W  = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(DATA_W - 1);
    localparam logic [FL_W-1:0]  FLUSH_DONE = FL_W'(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        WAIT_CS = 2'd0,
        IDLE    = 2'd1,
        SHIFT   = 2'd2
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_prev, cs_prev;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] rx_shift, tx_shift;
    logic              skip_fall;
    logic [FL_W-1:0]   flush_cnt;

    logic start_word, rise_step, fall_step, end_frame, word_last;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign cs_fall   = ~cs_s & cs_prev;
    assign cs_rise   = cs_s & ~cs_prev;

    assign busy      = (state == SHIFT);
    assign state_dbg = state;
    assign word_last = rise_step && (bit_cnt == LAST_BIT);

    // Synchronise the async SPI pins and keep one previous sample for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '1;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b1;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= WAIT_CS;
        else     state <= state_next;
    end

    // Next state and per-cycle datapath commands; cs_rise outranks sclk edges
    always_comb begin
        state_next = state;
        start_word = 1'b0;
        rise_step  = 1'b0;
        fall_step  = 1'b0;
        end_frame  = 1'b0;
        case (state)
            // The synchroniser's reset value of 1 is not a real observation
            // of cs_n. Leave only after the chain and prev flop have been
            // refilled from the pin and both show cs_n high.
            WAIT_CS: if (flush_cnt == FLUSH_DONE && cs_s && cs_prev) state_next = IDLE;
            IDLE: begin
                if (cs_fall) begin
                    state_next = SHIFT;
                    start_word = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_next = IDLE;
                    end_frame  = 1'b1;
                end else if (sclk_rise) begin
                    rise_step = 1'b1;
                end else if (sclk_fall) begin
                    fall_step = 1'b1;
                end
            end
            default: state_next = WAIT_CS;
        endcase
    end

    // Shift registers, bit counter, miso and the done/frame_err strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            dout      <= '0;
            miso      <= 1'b0;
            done      <= 1'b0;
            frame_err <= 1'b0;
            skip_fall <= 1'b0;
            flush_cnt <= '0;
        end else begin
            done      <= 1'b0;
            frame_err <= 1'b0;
            if (state == WAIT_CS && flush_cnt != FLUSH_DONE)
                flush_cnt <= flush_cnt + 1'b1;
            if (start_word) begin
                bit_cnt   <= '0;
                rx_shift  <= '0;
                tx_shift  <= tx_data;
                miso      <= tx_data[DATA_W-1];
                skip_fall <= 1'b0;
            end
            if (end_frame) begin
                // A word that is not finished is dropped; dout is left alone
                bit_cnt   <= '0;
                miso      <= 1'b0;
                skip_fall <= 1'b0;
                frame_err <= (bit_cnt != '0);
            end
            if (rise_step) begin
                rx_shift <= {rx_shift[DATA_W-2:0], mosi_s};
                if (word_last) begin
                    bit_cnt   <= '0;
                    dout      <= {rx_shift[DATA_W-2:0], mosi_s};
                    done      <= 1'b1;
                    tx_shift  <= tx_data;
                    miso      <= tx_data[DATA_W-1];
                    skip_fall <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
            if (fall_step) begin
                // miso already holds the new word's MSB after a reload
                if (skip_fall) begin
                    skip_fall <= 1'b0;
                end else begin
                    tx_shift <= tx_shift << 1;
                    miso     <= tx_shift[DATA_W-2];
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: random and directed SPI master stimulus for spi_slave_rx.
// The master side models the link as words in and words out. Every complete
// word pushed onto the line is expected on dout, in order. Every word's miso
// bits must equal the tx_data that was current when that word began. An
// abort with a partial word must produce exactly one frame_err.
module tb_spi_slave_rx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sclk = 1'b0;
    logic         cs_n = 1'b1;
    logic         mosi = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic         miso, done, frame_err, busy;
    logic [W-1:0] dout;
    logic [1:0]   state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int exp_done = 0;
    int ferr_cnt = 0;
    int exp_ferr = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_word = '0;

    spi_slave_rx #(.DATA_W(W), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .tx_data(tx_data), .dout(dout), .done(done),
        .frame_err(frame_err), .busy(busy), .state_dbg(state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every done pulse must deliver the oldest outstanding word
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                done_cnt++;
                check("done_with_ferr", 32'(frame_err), 32'd0);
                if (exp_q.size() == 0) begin
                    check("spurious_done", 32'(done), 32'd0);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    check("dout", 32'(dout), 32'(e));
                    last_word = e;
                end
            end
            if (frame_err) ferr_cnt++;
        end
    end

    // Driver: one word (or a partial word of nbits) in mode 0, sclk = clk/8.
    // The response for the following word is presented during the last bit.
    task automatic xfer(input logic [W-1:0] word, input int nbits,
                        input logic [W-1:0] cur_tx, input logic [W-1:0] next_tx);
        logic [W-1:0] got;
        got = '0;
        if (nbits == W) begin
            exp_q.push_back(word);
            exp_done++;
        end
        for (int i = 0; i < nbits; i++) begin
            mosi = word[W-1-i];
            if (i == W - 1) tx_data = next_tx;
            repeat (4) @(negedge clk);
            got[W-1-i] = miso;
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        if (nbits == W) check("miso_word", 32'(got), 32'(cur_tx));
    endtask

    task automatic cs_start(input logic [W-1:0] first_tx);
        tx_data = first_tx;
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic cs_end();
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'(exp_done));
        check({tag, "_ferr_cnt"}, 32'(ferr_cnt), 32'(exp_ferr));
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Random frame of nwords full words, optionally ending with an aborted partial word
    task automatic random_frame(input int nwords, input int abort_bits);
        logic [W-1:0] cur, nxt;
        cur = W'($urandom);
        cs_start(cur);
        for (int k = 0; k < nwords; k++) begin
            nxt = W'($urandom);
            xfer(W'($urandom), W, cur, nxt);
            cur = nxt;
        end
        if (abort_bits > 0) begin
            xfer(W'($urandom), abort_bits, cur, W'($urandom));
            exp_ferr++;
        end
        cs_end();
        if (abort_bits > 0) check("abort_dout_hold", 32'(dout), 32'(last_word));
        check_counts("rand");
    endtask

    initial begin
        // Reset with cs_n idle
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state_wait_cs", 32'(state_dbg), 32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("state_idle", 32'(state_dbg), 32'd1);

        // Single word
        cs_start(8'h3C);
        check("busy_in_frame", 32'(busy), 32'd1);
        xfer(8'hA5, W, 8'h3C, 8'h00);
        cs_end();
        check("busy_after_frame", 32'(busy), 32'd0);
        check_counts("single");

        // Back-to-back words with changing responses
        cs_start(8'h11);
        xfer(8'h01, W, 8'h11, 8'h22);
        xfer(8'hFF, W, 8'h22, 8'h33);
        xfer(8'h80, W, 8'h33, 8'h44);
        cs_end();
        check_counts("b2b");

        // Abort after 5 bits, then a good word
        cs_start(8'h77);
        xfer(8'hF0, 5, 8'h77, 8'h00);
        exp_ferr++;
        cs_end();
        check("abort_dout_hold", 32'(dout), 32'(last_word));
        check_counts("abort");
        cs_start(8'h99);
        xfer(8'h5A, W, 8'h99, 8'h00);
        cs_end();
        check_counts("after_abort");

        // Reset mid-frame with cs_n held low
        cs_start(8'h66);
        xfer(8'hC3, 3, 8'h66, 8'h00);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_word = '0;
        xfer(8'hFF, 5, 8'h00, 8'h00);
        check("midrst_dout", 32'(dout), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_state_wait_cs", 32'(state_dbg), 32'd0);
        cs_end();
        check_counts("midrst");
        cs_start(8'hE7);
        xfer(8'hC3, W, 8'hE7, 8'h00);
        cs_end();
        check_counts("post_rst");

        // sclk/mosi noise with cs_n high
        for (int i = 0; i < 24; i++) begin
            sclk = ~sclk;
            mosi = 1'($urandom);
            repeat ($urandom_range(4, 6)) @(negedge clk);
            check("noise_busy", 32'(busy), 32'd0);
            check("noise_miso", 32'(miso), 32'd0);
        end
        sclk = 1'b0;
        repeat (6) @(negedge clk);
        check_counts("noise");

        // Random frames
        for (int f = 0; f < 15; f++) begin
            random_frame($urandom_range(1, 3),
                         ($urandom_range(0, 2) == 0) ? $urandom_range(1, W - 1) : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
